// File: rtl/top_stream_checker.sv
// top_stream_checker: passive monitor for a valid/ready/data stream.
// Flags handshake violations as one-cycle registered pulses (err_drop,
// err_data, err_timeout), keeps a sticky err_any and counts completed
// transfers in a wrapping counter. It never drives the monitored stream.
//
// Handshake rule being checked: once valid is high with ready low (a stall),
// valid must stay high and data must stay constant until the cycle in which
// ready is high; that cycle completes the transfer.
//
// Optional build macro MAGMA_CHECKER_ASSERT_EN compiles in concurrent
// assertions mirroring the three rules. Without it the module holds only the
// flags and the counter; the port list is the same either way.
//
// Monitor state is held in state_q (ST_IDLE / ST_STALLED) so checkers can
// bind to it hierarchically.
module top_stream_checker #(
   parameter int DATA_W    = 8,
   parameter int MAX_STALL = 16,
   parameter int CNT_W     = 16
) (
   input  logic              CLK,
   input  logic              ASYNCRESETN,
   input  logic              valid,
   input  logic              ready,
   input  logic [DATA_W-1:0] data,
   output logic              err_drop,
   output logic              err_data,
   output logic              err_timeout,
   output logic              err_any,
   output logic [CNT_W-1:0]  xfer_count
);

   localparam int SC_W = $clog2(MAX_STALL + 1);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_STALLED = 1'b1;

   localparam logic [SC_W-1:0] STALL_ONE  = SC_W'(1);
   localparam logic [SC_W-1:0] STALL_MAX  = SC_W'(MAX_STALL);
   localparam logic [SC_W-1:0] STALL_LAST = SC_W'(MAX_STALL - 1);

   logic [0:0]        state_q, state_d;
   logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [DATA_W-1:0] cap_q, cap_d;
   logic [CNT_W-1:0]  xfer_count_q, xfer_count_d;
   logic              err_drop_q, err_drop_d;
   logic              err_data_q, err_data_d;
   logic              err_timeout_q, err_timeout_d;
   logic              err_any_q, err_any_d;

   // Next-state evaluation of the monitor; STALLED checks run in priority order
   always_comb begin
      state_d       = state_q;
      stall_cnt_d   = stall_cnt_q;
      cap_d         = cap_q;
      xfer_count_d  = xfer_count_q;
      err_drop_d    = 1'b0;
      err_data_d    = 1'b0;
      err_timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (valid) begin
               if (ready) begin
                  xfer_count_d = xfer_count_q + CNT_W'(1);
               end else begin
                  cap_d       = data;
                  stall_cnt_d = STALL_ONE;
                  state_d     = ST_STALLED;
               end
            end
         end

         ST_STALLED: begin
            if (!valid) begin
               // Withdrawn valid ends the stall; data is not compared here.
               err_drop_d  = 1'b1;
               state_d     = ST_IDLE;
               stall_cnt_d = '0;
            end else begin
               // Re-capture on change so a persisting new value flags only once.
               if (data != cap_q) begin
                  err_data_d = 1'b1;
                  cap_d      = data;
               end
               if (ready) begin
                  xfer_count_d = xfer_count_q + CNT_W'(1);
                  state_d      = ST_IDLE;
                  stall_cnt_d  = '0;
               end else if (stall_cnt_q != STALL_MAX) begin
                  // Saturating count; the timeout fires only on reaching the limit.
                  stall_cnt_d = stall_cnt_q + STALL_ONE;
                  if (stall_cnt_q == STALL_LAST) begin
                     err_timeout_d = 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d     = ST_IDLE;
            stall_cnt_d = '0;
         end
      endcase

      err_any_d = err_any_q | err_drop_d | err_data_d | err_timeout_d;
   end

   // State, counters and registered flag pulses; reset takes effect immediately
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q       <= ST_IDLE;
         stall_cnt_q   <= '0;
         cap_q         <= '0;
         xfer_count_q  <= '0;
         err_drop_q    <= 1'b0;
         err_data_q    <= 1'b0;
         err_timeout_q <= 1'b0;
         err_any_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         stall_cnt_q   <= stall_cnt_d;
         cap_q         <= cap_d;
         xfer_count_q  <= xfer_count_d;
         err_drop_q    <= err_drop_d;
         err_data_q    <= err_data_d;
         err_timeout_q <= err_timeout_d;
         err_any_q     <= err_any_d;
      end
   end

   assign err_drop    = err_drop_q;
   assign err_data    = err_data_q;
   assign err_timeout = err_timeout_q;
   assign err_any     = err_any_q;
   assign xfer_count  = xfer_count_q;

`ifdef MAGMA_CHECKER_ASSERT_EN
   // A stalled beat must keep valid asserted on the following edge
   a_valid_hold : assert property (
      @(posedge CLK) disable iff (!ASYNCRESETN)
      (valid && !ready) |=> valid
   ) else $error("valid_hold rule violated, xfer_count=%0d", xfer_count_q);

   // A stalled beat must keep its data on the following edge
   a_data_stable : assert property (
      @(posedge CLK) disable iff (!ASYNCRESETN)
      (valid && !ready) |=> $stable(data)
   ) else $error("data_stable rule violated, xfer_count=%0d", xfer_count_q);

   // No stall may last MAX_STALL cycles
   a_stall_limit : assert property (
      @(posedge CLK) disable iff (!ASYNCRESETN)
      !err_timeout_d
   ) else $error("stall_timeout rule violated, xfer_count=%0d", xfer_count_q);
`endif

endmodule

// File: tb/tb_top_stream_checker.sv
// tb_top_stream_checker: directed vectors for top_stream_checker.
// Each driven vector carries its hand-computed post-edge outputs, which are
// queued; a monitor process pops one entry after every sampling edge and
// compares state, the three pulse flags, err_any and xfer_count.
// The DUT is built with CNT_W=4 so counter wrap is reachable quickly.
module tb_top_stream_checker;

   localparam int DATA_W    = 8;
   localparam int MAX_STALL = 16;
   localparam int CNT_W     = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              valid = 1'b0;
   logic              ready = 1'b0;
   logic [DATA_W-1:0] data = '0;
   logic              err_drop, err_data, err_timeout, err_any;
   logic [CNT_W-1:0]  xfer_count;

   int n_checks = 0;
   int n_fail   = 0;

   // expected entry: {state, drop, data, timeout, any, count[3:0]}
   logic [8:0] exp_q[$];
   logic [8:0] mon_e;

   top_stream_checker #(
      .DATA_W   (DATA_W),
      .MAX_STALL(MAX_STALL),
      .CNT_W    (CNT_W)
   ) dut (
      .CLK        (clk),
      .ASYNCRESETN(rst_n),
      .valid      (valid),
      .ready      (ready),
      .data       (data),
      .err_drop   (err_drop),
      .err_data   (err_data),
      .err_timeout(err_timeout),
      .err_any    (err_any),
      .xfer_count (xfer_count)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // drive one cycle of inputs at the falling edge and queue its expected outputs
   task automatic drive(input logic v, input logic r, input logic [7:0] d,
                        input logic st, input logic dr, input logic de,
                        input logic to, input logic an, input logic [3:0] cnt);
      @(negedge clk);
      valid = v;
      ready = r;
      data  = d;
      exp_q.push_back({st, dr, de, to, an, cnt});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_err_drop"},    err_drop,    0);
      check({tag, "_err_data"},    err_data,    0);
      check({tag, "_err_timeout"}, err_timeout, 0);
      check({tag, "_err_any"},     err_any,     0);
      check({tag, "_xfer_count"},  xfer_count,  0);
      check({tag, "_state"},       dut.state_q, 0);
   endtask

   // monitor: compare after every edge that sampled a queued vector
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("state",       dut.state_q, mon_e[8]);
            check("err_drop",    err_drop,    mon_e[7]);
            check("err_data",    err_data,    mon_e[6]);
            check("err_timeout", err_timeout, mon_e[5]);
            check("err_any",     err_any,     mon_e[4]);
            check("xfer_count",  xfer_count,  mon_e[3:0]);
         end
      end
   end

   // stimulus
   initial begin
      rst_n = 1'b0;
      #2;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // five back-to-back transfers
      for (int i = 0; i < 5; i++) drive(1, 1, 8'(8'h10 + i), 0, 0, 0, 0, 0, 4'(i + 1));
      drive(0, 0, 8'h00, 0, 0, 0, 0, 0, 5);

      // legal stall of three cycles, then transfer
      repeat (3) drive(1, 0, 8'hA5, 1, 0, 0, 0, 0, 5);
      drive(1, 1, 8'hA5, 0, 0, 0, 0, 0, 6);
      drive(0, 0, 8'h00, 0, 0, 0, 0, 0, 6);

      // data change while stalled
      drive(1, 0, 8'hA5, 1, 0, 0, 0, 0, 6);
      drive(1, 0, 8'h5A, 1, 0, 1, 0, 1, 6);
      drive(1, 0, 8'h5A, 1, 0, 0, 0, 1, 6);
      drive(1, 1, 8'h5A, 0, 0, 0, 0, 1, 7);

      // valid dropped while stalled
      drive(1, 0, 8'h33, 1, 0, 0, 0, 1, 7);
      drive(0, 0, 8'h33, 0, 1, 0, 0, 1, 7);
      drive(0, 0, 8'h00, 0, 0, 0, 0, 1, 7);
      drive(1, 1, 8'h44, 0, 0, 0, 0, 1, 8);

      // 20-cycle stall: timeout once on the 16th stalled edge, then saturates
      for (int i = 0; i < 20; i++) drive(1, 0, 8'h77, 1, 0, 0, (i == 15), 1, 8);
      drive(1, 1, 8'h77, 0, 0, 0, 0, 1, 9);

      // data change on the same edge that reaches the stall limit
      for (int i = 0; i < 15; i++) drive(1, 0, 8'h11, 1, 0, 0, 0, 1, 9);
      drive(1, 0, 8'h22, 1, 0, 1, 1, 1, 9);
      drive(1, 1, 8'h22, 0, 0, 0, 0, 1, 10);

      // asynchronous reset between edges, mid-stall
      for (int i = 0; i < 10; i++) drive(1, 0, 8'h55, 1, 0, 0, 0, 1, 10);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      valid = 1'b0;
      ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // fresh stall after reset: 10 cycles must not reach the limit
      for (int i = 0; i < 10; i++) drive(1, 0, 8'h66, 1, 0, 0, 0, 0, 0);
      drive(1, 1, 8'h66, 0, 0, 0, 0, 0, 1);

      // 16 more transfers: 17 since reset, 4-bit counter wraps to 1
      for (int i = 0; i < 16; i++) drive(1, 1, 8'(i), 0, 0, 0, 0, 0, 4'(i + 2));
      drive(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
